// File: rtl/serial_frame_pkg.sv
// Shared types and widths for the bit-serial frame transmitter.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } tx_state_e;

    localparam int BUF_W     = 64;
    localparam int BIT_IDX_W = 6;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts CLK_DIV system clocks per serial bit while run is high.
module bit_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_start,
    output logic half
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != CNT_W'(CLK_DIV - 1))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Strobes flag the cycle the next edge enters, so the caller can register outputs on that edge.
    assign bit_start = run && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign half      = run && (cnt_q == CNT_W'(CLK_DIV / 2 - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Collects up to eight bytes and shifts them out LSB first on a frame/clock/data link.
module serial_frame_tx #(
    parameter int CLK_DIV = 16,
    parameter int BYTES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       load,
    input  logic       start,
    output logic       tx_frame,
    output logic       tx_clk,
    output logic       tx_data,
    output logic       busy,
    output logic       full,
    output logic [3:0] count
);

    import serial_frame_pkg::*;

    tx_state_e            state_q, state_d;
    logic [BUF_W-1:0]     buf_q, buf_d;
    logic [3:0]           count_q, count_d;
    logic                 full_q, full_d;
    logic                 busy_q, busy_d;
    logic                 tx_frame_q, tx_frame_d;
    logic                 tx_clk_q, tx_clk_d;
    logic                 tx_data_q, tx_data_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [BIT_IDX_W-1:0] last_idx_q, last_idx_d;

    logic                 bit_start;
    logic                 half;
    logic                 load_ok;
    logic                 start_ok;
    logic [3:0]           count_ld;
    logic [6:0]           nbits;
    logic [BIT_IDX_W-1:0] bit_next;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state_q != IDLE),
        .bit_start (bit_start),
        .half      (half)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        busy_d     = busy_q;
        tx_frame_d = tx_frame_q;
        tx_clk_d   = tx_clk_q;
        tx_data_d  = tx_data_q;
        bit_idx_d  = bit_idx_q;
        last_idx_d = last_idx_q;

        load_ok  = (state_q == IDLE) && ena && load && !full_q;
        count_ld = count_q + {3'b000, load_ok};
        nbits    = {count_ld, 3'b000};
        // A same-cycle load counts toward the frame, so an empty buffer plus load still starts.
        start_ok = (state_q == IDLE) && ena && start && (count_ld != 4'd0);
        bit_next = bit_idx_q + BIT_IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    buf_d[{count_q[2:0], 3'b000} +: 8] = data_in;
                    count_d = count_ld;
                end
                if (start_ok) begin
                    state_d    = LEAD;
                    last_idx_d = BIT_IDX_W'(nbits - 7'd1);
                    bit_idx_d  = '0;
                    tx_frame_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            LEAD: begin
                if (bit_start) begin
                    state_d   = SHIFT;
                    bit_idx_d = '0;
                    tx_data_d = buf_q[0];
                end
            end
            SHIFT: begin
                if (half) begin
                    tx_clk_d = 1'b1;
                end
                if (bit_start) begin
                    tx_clk_d = 1'b0;
                    if (bit_idx_q == last_idx_q) begin
                        state_d   = TRAIL;
                        tx_data_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_next;
                        tx_data_d = buf_q[bit_next];
                    end
                end
            end
            TRAIL: begin
                if (bit_start) begin
                    state_d    = IDLE;
                    tx_frame_d = 1'b0;
                    tx_data_d  = 1'b0;
                    busy_d     = 1'b0;
                    count_d    = '0;
                    buf_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d = (count_d == 4'(BYTES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_frame_q <= 1'b0;
            tx_clk_q   <= 1'b0;
            tx_data_q  <= 1'b0;
            bit_idx_q  <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            tx_frame_q <= tx_frame_d;
            tx_clk_q   <= tx_clk_d;
            tx_data_q  <= tx_data_d;
            bit_idx_q  <= bit_idx_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign tx_frame = tx_frame_q;
    assign tx_clk   = tx_clk_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: table of load/start vectors plus a byte-queue frame model.
module tb_serial_frame_tx;

    localparam int CLK_DIV = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load    = 1'b0;
    logic       start   = 1'b0;
    logic       tx_frame;
    logic       tx_clk;
    logic       tx_data;
    logic       busy;
    logic       full;
    logic [3:0] count;

    int tests = 0;
    int fails = 0;

    logic [7:0] mdl[$];

    typedef struct {
        logic       en;
        logic       ld;
        logic       st;
        logic [7:0] d;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    serial_frame_tx #(
        .CLK_DIV (CLK_DIV),
        .BYTES   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .load     (load),
        .start    (start),
        .tx_frame (tx_frame),
        .tx_clk   (tx_clk),
        .tx_data  (tx_data),
        .busy     (busy),
        .full     (full),
        .count    (count)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of strobes from IDLE and mirrors accepted loads into the byte queue.
    task automatic applyStimulus(input logic en, input logic ld, input logic st, input logic [7:0] d);
        ena     = en;
        load    = ld;
        start   = st;
        data_in = d;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        ena   = 1'b1;
        if (en && ld && mdl.size() < 8) mdl.push_back(d);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called one cycle after the accepting edge; poke_at >= 0 fires load+start mid-frame.
    task automatic runFrame(input string name, input int poke_at);
        int          nbits;
        logic [63:0] exp_bits;
        logic [63:0] cap_bits;
        int          caps;
        int          bad;
        int          frame_len;
        int          per;
        int          ph;
        logic        e_clk;
        logic        e_data;
        logic        prev_clk;
        logic [3:0]  count_at_start;

        nbits    = 8 * mdl.size();
        exp_bits = '0;
        for (int j = 0; j < mdl.size(); j++) exp_bits[8*j +: 8] = mdl[j];
        cap_bits       = '0;
        caps           = 0;
        bad            = 0;
        frame_len      = 0;
        prev_clk       = 1'b0;
        count_at_start = count;

        while (tx_frame === 1'b1 && frame_len < 400) begin
            per    = frame_len / CLK_DIV;
            ph     = frame_len % CLK_DIV;
            e_clk  = (per >= 1 && per <= nbits && ph >= CLK_DIV / 2);
            e_data = (per >= 1 && per <= nbits) ? exp_bits[per-1] : 1'b0;
            if (tx_clk !== e_clk || tx_data !== e_data || busy !== 1'b1 || count !== count_at_start)
                bad++;
            if (!prev_clk && tx_clk === 1'b1) begin
                if (caps < 64) cap_bits[caps] = tx_data;
                caps++;
            end
            prev_clk = tx_clk;
            if (frame_len == poke_at) begin
                ena     = 1'b1;
                load    = 1'b1;
                start   = 1'b1;
                data_in = 8'hFF;
            end
            @(posedge clk);
            #1;
            load  = 1'b0;
            start = 1'b0;
            frame_len++;
        end

        checkOutput({name, " frame_len"}, 64'(frame_len), 64'((nbits + 2) * CLK_DIV));
        checkOutput({name, " trace_errors"}, 64'(bad), 64'd0);
        checkOutput({name, " captures"}, 64'(caps), 64'(nbits));
        checkOutput({name, " captured_bits"}, cap_bits, exp_bits);
        checkOutput({name, " idle_after"}, {59'd0, busy, full, count != 4'd0, tx_clk, tx_data}, 64'd0);
        mdl.delete();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 4'd0, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            vecs[i] = '{1'b1, 1'b1, 1'b0, 8'(i), 4'(i), (i == 8), 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h09, 4'd8, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 4'd8, 1'b1, 1'b0};

        step(2);
        checkOutput("reset_outputs", {55'd0, tx_frame, tx_clk, tx_data, busy, full, count}, 64'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        step(1);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        step(2);
        checkOutput("empty_start", {62'd0, busy, tx_frame}, 64'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
        checkOutput("a5_count", 64'(count), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        runFrame("single_a5", -1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].ld, vecs[i].st, vecs[i].d);
            checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_flags", i), {62'd0, full, busy},
                        {62'd0, vecs[i].exp_full, vecs[i].exp_busy});
        end
        checkOutput("full_frame_model", 64'(mdl.size()), 64'd8);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        runFrame("full_64", -1);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
        runFrame("load_start_3c", -1);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        runFrame("busy_gating", 10);
        step(2);
        checkOutput("busy_gating_after", {59'd0, busy, tx_frame, count}, 64'd0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++)
                applyStimulus(($urandom_range(0, 3) != 0), 1'b1, 1'b0, 8'($urandom));
            if (mdl.size() == 0) applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom));
            checkOutput($sformatf("rand%0d_count", r), 64'(count), 64'(mdl.size()));
            applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
            runFrame($sformatf("rand%0d", r), -1);
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        step(CLK_DIV + 3);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_frame", {55'd0, tx_frame, tx_clk, tx_data, busy, full, count}, 64'd0);
        mdl.delete();
        #3 rst_n = 1'b1;
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        step(2);
        checkOutput("start_after_reset", {62'd0, busy, tx_frame}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serializer that collects up to eight bytes from the input switch bus into a 64-bit buffer and shifts them out, LSB first, on a three-wire synchronous link: frame, clock and data. It is the transmit end of the team's bit-serial capture path, where the receiver stores one bit per sampled clock into a 64-bit register at an incrementing index. It sits beside the 7-segment output logic in the TinyTapeout top and drives the bidirectional pins configured as outputs.

## Interface
- `CLK_DIV`, 16: system clocks per serial bit. Must be even and ≥ 2.
- `BYTES`, 8: buffer depth in bytes. Fixed at 8 for the 64-bit frame.

- `clk` input 1: system clock. All state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: design enable. While low, `load` and `start` are ignored.
- `data_in` input 8: byte to store.
- `load` input 1: write strobe, one byte per high cycle.
- `start` input 1: begin transmission of the buffered bytes.
- `tx_frame` output 1: high for the whole frame.
- `tx_clk` output 1: serial clock. The receiver samples `tx_data` on its rising edge.
- `tx_data` output 1: serial data.
- `busy` output 1: high from the cycle after an accepted `start` until return to IDLE.
- `full` output 1: `count == BYTES`.
- `count` output 4: bytes currently buffered, range 0..8.

## Operation
- **Reset values:** all outputs are 0, the buffer is cleared and the state is IDLE. Assertion mid-frame aborts the frame immediately and asynchronously.
- **Load:**
  - In IDLE, `load && ena && !full` writes `data_in` to buffer byte `count` (bits `8*count+7 : 8*count`), then increments `count`.
  - A load when `full`, or in any state other than IDLE, is dropped with no side effect.
- **Start:**
  - In IDLE, `start && ena && (count != 0 || load accepted this cycle)` is accepted.
  - If `load` and `start` occur in the same cycle, the byte is stored and included in the frame.
  - `start` while busy or with an empty buffer is ignored.
- **States:**
  - **IDLE:** an accepted `start` moves to LEAD. The number of bits to send, N = 8 × count, is latched at this point.
  - **LEAD:** one bit period with `tx_frame` = 1, `tx_clk` = 0 and `tx_data` = 0. Then moves to SHIFT.
  - **SHIFT:** N bit periods. Bit k (k = 0..N−1) is buffer bit k, so byte 0 goes out first, LSB first. Then moves to TRAIL.
  - **TRAIL:** one bit period with `tx_frame` = 1 and `tx_clk` = 0. Then returns to IDLE. On the transition to IDLE, `tx_frame`, `tx_data` and `busy` return to 0, `count` is cleared and the buffer is zeroed.
- **Bit period:**
  - `tx_data` changes only at the first cycle of a bit period.
  - `tx_clk` is 0 for the first `CLK_DIV/2` cycles and 1 for the last `CLK_DIV/2` cycles of each SHIFT bit.
- **ena low mid-frame:** the frame continues unaffected.
- **Arithmetic:**
  - The divider counter is `$clog2(CLK_DIV)` bits and wraps at `CLK_DIV−1`.
  - The bit index is 6 bits, covering 0..63. The SHIFT → TRAIL test is `bit_idx == N−1`, with no wrap past 63.

## Timing
- **Start latency:** accepted `start` at edge t gives `tx_frame` and `busy` = 1 from edge t+1.
- **First data bit:** SHIFT bit 0 drives `tx_data` from edge t+1+`CLK_DIV`.
- **Frame length:** `tx_frame` is high for (N+2)·`CLK_DIV` cycles.
- **Next start:** a new `start` is accepted no earlier than the cycle after `busy` falls, and only after at least one new load.
- **Registered outputs:** all outputs come straight from flops, with no combinational path from inputs to outputs.

## Structure
- **Package `serial_frame_pkg`:**
  - state enum `{IDLE, LEAD, SHIFT, TRAIL}`
  - `BUF_W` = 64
  - `BIT_IDX_W` = 6
- **Sub-module `bit_tick_gen`:** the `CLK_DIV` divider.
  - Inputs: `clk`, `rst_n`, `run`.
  - Outputs: `bit_start` (first cycle of a period) and `half` (start of the high phase).
  - Held at count 0 while `run` is 0.
- **Top-level wiring:** the top maps `tx_frame`, `tx_clk` and `tx_data` to `uio_out[0:2]` with `uio_oe[2:0]` = 3'b111.

## Test plan
- **Reset mid-frame:** assert `rst_n` = 0 mid-SHIFT → all outputs 0 within the same cycle, `count` = 0, and the next `start` is ignored until a load.
- **Single byte, `CLK_DIV` = 4:** load 8'hA5, then start →
  - `tx_frame` high for 40 cycles;
  - `tx_data` sampled on `tx_clk` rising edges = 1,0,1,0,0,1,0,1;
  - `busy` falls and `count` = 0 afterwards.
- **Full 64-bit frame:** load bytes 8'h01..8'h08, then start →
  - a capture model (bit k stored at index k) reconstructs 64'h0807060504030201;
  - `full` = 1 before start;
  - a 9th load is dropped.
- **Corner strobes:**
  - `load` 8'h3C with `start` in the same cycle on an empty buffer → one-byte frame carrying 8'h3C.
  - `start` on an empty buffer → no activity.
- **Busy and enable gating:**
  - `load` and `start` during `busy` are ignored: `count` stays 0 and the frame is unchanged.
  - `ena` = 0 with `start` → no frame.
